// File: rtl/gb_lcd_pkg.sv
// ---------------------------------------------------------------------------
// gb_lcd_pkg
// Shared definitions for the LCD pixel transmit path:
//   - STAT mode encodings (lcd_mode_e)
//   - DMG/GBC line and frame timing constants
//   - pixel and counter widths
//   - mode_for(): STAT mode of the dot being entered
// No ports (package).
// ---------------------------------------------------------------------------
package gb_lcd_pkg;

  localparam int unsigned DOTS_PER_LINE = 456;
  localparam int unsigned LINES         = 154;
  localparam int unsigned VIS_LINES     = 144;
  localparam int unsigned OAM_DOTS      = 80;
  localparam int unsigned H_PIX         = 160;

  localparam int unsigned PIX_W    = 15;
  localparam int unsigned DOT_W    = 9;
  localparam int unsigned LY_W     = 8;
  localparam int unsigned PIXCNT_W = 8;

  typedef enum logic [1:0] {
    MODE_HBL  = 2'd0,
    MODE_VBL  = 2'd1,
    MODE_OAM  = 2'd2,
    MODE_XFER = 2'd3
  } lcd_mode_e;

  // Mode for a dot about to be entered. pixcnt is the pixel count that will
  // hold after that edge, so the 160th transfer ends mode 3 immediately.
  function automatic lcd_mode_e mode_for(
    input logic                vblank,
    input logic [DOT_W-1:0]    dot,
    input logic [PIXCNT_W-1:0] pixcnt
  );
    if (vblank)                         return MODE_VBL;
    if (dot < DOT_W'(OAM_DOTS))         return MODE_OAM;
    if (pixcnt < PIXCNT_W'(H_PIX))      return MODE_XFER;
    return MODE_HBL;
  endfunction

endpackage

// File: rtl/lcd_tx_timing.sv
// ---------------------------------------------------------------------------
// lcd_tx_timing
// Dot and line counters for the LCD transmit side, plus look-ahead strobes.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_ce           dot clock enable
//   i_on           LCD enable; counters clear and hold while low
//   o_ly           current line
//   o_dot_next     dot that the next advancing edge enters
//   o_vblank_next  line that the next advancing edge enters is vblank
//   o_adv          counters advance on this edge (ce & on)
//   o_line_wrap    this edge leaves dot 455
//   o_vs_start     this edge enters line 144 dot 0
// ---------------------------------------------------------------------------
module lcd_tx_timing
  import gb_lcd_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce,
  input  logic            i_on,
  output logic [LY_W-1:0] o_ly,
  output logic [DOT_W-1:0] o_dot_next,
  output logic            o_vblank_next,
  output logic            o_adv,
  output logic            o_line_wrap,
  output logic            o_vs_start
);

  logic [DOT_W-1:0] r_dot;
  logic [LY_W-1:0]  r_ly;

  logic             w_dot_last;
  logic             w_ly_last;
  logic [DOT_W-1:0] w_dot_next;
  logic [LY_W-1:0]  w_ly_next;

  assign w_dot_last = (r_dot == DOT_W'(DOTS_PER_LINE - 1));
  assign w_ly_last  = (r_ly == LY_W'(LINES - 1));
  assign w_dot_next = w_dot_last ? '0 : r_dot + DOT_W'(1);
  assign w_ly_next  = w_dot_last ? (w_ly_last ? '0 : r_ly + LY_W'(1)) : r_ly;

  assign o_adv         = i_ce & i_on;
  assign o_line_wrap   = o_adv & w_dot_last;
  assign o_vs_start    = o_line_wrap & (r_ly == LY_W'(VIS_LINES - 1));
  assign o_dot_next    = w_dot_next;
  assign o_vblank_next = (w_ly_next >= LY_W'(VIS_LINES));
  assign o_ly          = r_ly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dot <= '0;
      r_ly  <= '0;
    end else if (!i_on) begin
      r_dot <= '0;
      r_ly  <= '0;
    end else if (i_ce) begin
      r_dot <= w_dot_next;
      r_ly  <= w_ly_next;
    end
  end

endmodule

// File: rtl/lcd_pixel_tx.sv
// ---------------------------------------------------------------------------
// lcd_pixel_tx
// Transmit end of the LCD pixel interface. Generates line/frame timing,
// drains the PPU pixel pipeline over valid/ready and drives the LCD stream.
// Ports:
//   i_clk_sys     system clock
//   i_reset_n     asynchronous active-low reset
//   i_ce          dot clock enable
//   i_on          LCDC.7 LCD enable
//   i_pix_valid   pipeline has a pixel
//   i_pix_data    pixel value (RGB555, or DMG shade in [1:0])
//   o_pix_ready   pixel accepted this cycle when valid & ready
//   o_lcd_clkena  one-cycle pixel strobe
//   o_data        pixel value, qualified by o_lcd_clkena
//   o_mode        STAT mode (0 hblank, 1 vblank, 2 OAM, 3 transfer)
//   o_lcd_vs      vsync pulse on entry to line 144
//   o_ly          current line
//   o_underrun    sticky: a line ended short of 160 pixels
// ---------------------------------------------------------------------------
module lcd_pixel_tx
  import gb_lcd_pkg::*;
(
  input  logic             i_clk_sys,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_on,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_pix_ready,
  output logic             o_lcd_clkena,
  output logic [PIX_W-1:0] o_data,
  output logic [1:0]       o_mode,
  output logic             o_lcd_vs,
  output logic [LY_W-1:0]  o_ly,
  output logic             o_underrun
);

  lcd_mode_e             r_mode;
  logic [PIXCNT_W-1:0]   r_pixcnt;
  logic                  r_clkena;
  logic [PIX_W-1:0]      r_data;
  logic                  r_vs;
  logic                  r_underrun;
  logic                  r_on_q;

  logic                  w_adv;
  logic                  w_line_wrap;
  logic                  w_vs_start;
  logic                  w_vblank_next;
  logic [DOT_W-1:0]      w_dot_next;
  logic                  w_pix_ready;
  logic                  w_xfer;
  logic                  w_last_pix;
  logic                  w_underrun_set;
  logic [PIXCNT_W-1:0]   w_pixcnt_next;
  lcd_mode_e             w_mode_next;

  lcd_tx_timing u_timing (
    .i_clk         (i_clk_sys),
    .i_rst_n       (i_reset_n),
    .i_ce          (i_ce),
    .i_on          (i_on),
    .o_ly          (o_ly),
    .o_dot_next    (w_dot_next),
    .o_vblank_next (w_vblank_next),
    .o_adv         (w_adv),
    .o_line_wrap   (w_line_wrap),
    .o_vs_start    (w_vs_start)
  );

  assign w_pix_ready = i_ce & i_on & (r_mode == MODE_XFER) &
                       (r_pixcnt < PIXCNT_W'(H_PIX));
  assign w_xfer      = i_pix_valid & w_pix_ready;
  assign w_last_pix  = w_xfer & (r_pixcnt == PIXCNT_W'(H_PIX - 1));

  // Leaving dot 455 still in transfer means the line was starved, unless the
  // 160th pixel is being taken on that very edge.
  assign w_underrun_set = w_line_wrap & (r_mode == MODE_XFER) & ~w_last_pix;

  // Next-state for the mode register.
  always_comb begin
    w_pixcnt_next = r_pixcnt;
    w_mode_next   = r_mode;
    if (w_line_wrap) begin
      w_pixcnt_next = '0;
    end else if (w_xfer) begin
      w_pixcnt_next = r_pixcnt + PIXCNT_W'(1);
    end
    if (!i_on) begin
      w_mode_next = MODE_HBL;
    end else if (w_adv) begin
      w_mode_next = mode_for(w_vblank_next, w_dot_next, w_pixcnt_next);
    end else if (!r_on_q) begin
      // Enabled without a dot enable yet: frame sits at ly 0 dot 0 in OAM.
      w_mode_next = MODE_OAM;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode <= MODE_HBL;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pixcnt   <= '0;
      r_clkena   <= 1'b0;
      r_data     <= '0;
      r_vs       <= 1'b0;
      r_underrun <= 1'b0;
      r_on_q     <= 1'b0;
    end else begin
      r_on_q   <= i_on;
      // Strobes are single-cycle; both are already gated by ce & on.
      r_clkena <= w_xfer;
      r_vs     <= w_vs_start;
      if (w_xfer) begin
        r_data <= i_pix_data;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end
      if (!i_on) begin
        r_pixcnt <= '0;
      end else if (w_adv) begin
        r_pixcnt <= w_pixcnt_next;
      end
    end
  end

  assign o_pix_ready  = w_pix_ready;
  assign o_lcd_clkena = r_clkena;
  assign o_data       = r_data;
  assign o_mode       = r_mode;
  assign o_lcd_vs     = r_vs;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_lcd_pixel_tx.sv
// ---------------------------------------------------------------------------
// tb_lcd_pixel_tx
// Directed bench for lcd_pixel_tx: reset/idle, full line, stalled line,
// starved line, LCD off/on, and a full frame with a slowed dot enable
// around the start of vblank.
// ---------------------------------------------------------------------------
module tb_lcd_pixel_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        lcd_on;
  logic        pix_valid;
  logic [14:0] pix_data;

  logic        pix_ready;
  logic        lcd_clkena;
  logic [14:0] data;
  logic [1:0]  mode;
  logic        lcd_vs;
  logic [7:0]  ly;
  logic        underrun;

  lcd_pixel_tx dut (
    .i_clk_sys    (clk),
    .i_reset_n    (rst_n),
    .i_ce         (ce),
    .i_on         (lcd_on),
    .i_pix_valid  (pix_valid),
    .i_pix_data   (pix_data),
    .o_pix_ready  (pix_ready),
    .o_lcd_clkena (lcd_clkena),
    .o_data       (data),
    .o_mode       (mode),
    .o_lcd_vs     (lcd_vs),
    .o_ly         (ly),
    .o_underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side position and per-test tallies.
  int b_dot = 0;
  int b_ly = 0;
  int mode_end = 240;
  int strobe_cnt = 0;
  int data_err = 0;
  int exp_data = 0;
  bit data_chk = 1'b0;
  int vs_cyc = 0;
  int vs_ly = -1;
  int vs_dot = -1;
  int mode_err = 0;
  int pr_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tallies();
    strobe_cnt = 0;
    data_err = 0;
    vs_cyc = 0;
    vs_ly = -1;
    vs_dot = -1;
    mode_err = 0;
    pr_err = 0;
  endtask

  // One clock: advance the bench's own dot/line position when the driven
  // inputs advance the LCD, then sample outputs 1 time unit after the edge.
  task automatic tick();
    logic adv;
    int   em;
    adv = ce & lcd_on;
    @(posedge clk);
    #1;
    if (!lcd_on) begin
      b_dot = 0;
      b_ly = 0;
    end else if (adv) begin
      if (b_dot == 455) begin
        b_dot = 0;
        b_ly = (b_ly == 153) ? 0 : b_ly + 1;
      end else begin
        b_dot++;
      end
      if (b_ly >= 144)          em = 1;
      else if (b_dot < 80)      em = 2;
      else if (b_dot < mode_end) em = 3;
      else                      em = 0;
      if (int'(mode) != em) mode_err++;
    end
    if (lcd_clkena) begin
      strobe_cnt++;
      if (data_chk && int'(data) != exp_data) data_err++;
      exp_data++;
    end
    if (lcd_vs) begin
      vs_cyc++;
      vs_ly = b_ly;
      vs_dot = b_dot;
    end
    if (!ce && pix_ready) pr_err++;
  endtask

  // n dot enables back to back; pixel pipeline empty for dots [v_lo, v_hi).
  task automatic run_ce(input int n, input int v_lo, input int v_hi);
    for (int i = 0; i < n; i++) begin
      pix_valid = !(b_dot >= v_lo && b_dot < v_hi);
      pix_data = 15'(b_dot);
      ce = 1'b1;
      tick();
    end
  endtask

  initial begin
    int  done;
    bit  slow;

    rst_n = 1'b0;
    ce = 1'b0;
    lcd_on = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ---- 1: reset mid-line with outputs active, then idle with LCD off
    lcd_on = 1'b1;
    run_ce(100, 0, 0);
    check_val("t1_active_strobe", int'(lcd_clkena), 1);
    check_val("t1_active_mode", int'(mode), 3);
    rst_n = 1'b0;
    ce = 1'b0;
    lcd_on = 1'b0;
    pix_valid = 1'b0;
    #1;
    check_val("t1_rst_clkena", int'(lcd_clkena), 0);
    check_val("t1_rst_data", int'(data), 0);
    check_val("t1_rst_mode", int'(mode), 0);
    check_val("t1_rst_vs", int'(lcd_vs), 0);
    check_val("t1_rst_ly", int'(ly), 0);
    check_val("t1_rst_underrun", int'(underrun), 0);
    check_val("t1_rst_ready", int'(pix_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    clear_tallies();
    for (int i = 0; i < 20; i++) begin
      ce = 1'(i % 2);
      pix_valid = 1'b1;
      tick();
    end
    check_val("t1_idle_strobes", strobe_cnt, 0);
    check_val("t1_idle_vs", vs_cyc, 0);
    check_val("t1_idle_mode", int'(mode), 0);
    check_val("t1_idle_ly", int'(ly), 0);
    $display("test1 reset/idle done");

    // ---- 2: full line, pix_data = dot index
    clear_tallies();
    mode_end = 240;
    data_chk = 1'b1;
    exp_data = 80;
    lcd_on = 1'b1;
    run_ce(456, 0, 0);
    check_val("t2_mode_errs", mode_err, 0);
    check_val("t2_strobes", strobe_cnt, 160);
    check_val("t2_data_errs", data_err, 0);
    check_val("t2_underrun", int'(underrun), 0);
    check_val("t2_next_ly", int'(ly), 1);
    check_val("t2_next_mode", int'(mode), 2);
    data_chk = 1'b0;
    $display("test2 full line: strobes=%0d", strobe_cnt);

    // ---- 3: pipeline empty for 20 dots mid-transfer
    clear_tallies();
    mode_end = 260;
    run_ce(456, 150, 170);
    check_val("t3_mode_errs", mode_err, 0);
    check_val("t3_strobes", strobe_cnt, 160);
    check_val("t3_underrun", int'(underrun), 0);
    check_val("t3_next_ly", int'(ly), 2);
    $display("test3 stalled line: strobes=%0d", strobe_cnt);

    // ---- 4: starvation after 100 pixels, then a normal line
    clear_tallies();
    mode_end = 456;
    run_ce(456, 180, 456);
    check_val("t4_mode_errs", mode_err, 0);
    check_val("t4_strobes", strobe_cnt, 100);
    check_val("t4_underrun", int'(underrun), 1);
    check_val("t4_next_mode", int'(mode), 2);
    check_val("t4_next_ly", int'(ly), 3);
    clear_tallies();
    mode_end = 240;
    run_ce(456, 0, 0);
    check_val("t4_after_mode_errs", mode_err, 0);
    check_val("t4_after_strobes", strobe_cnt, 160);
    check_val("t4_after_sticky", int'(underrun), 1);
    $display("test4 starved line: underrun=%0d", underrun);

    // ---- 6: LCD off mid-line, then back on
    run_ce(756, 0, 0);
    check_val("t6_pre_ly", int'(ly), 5);
    check_val("t6_pre_mode", int'(mode), 0);
    lcd_on = 1'b0;
    tick();
    check_val("t6_off_ly", int'(ly), 0);
    check_val("t6_off_mode", int'(mode), 0);
    check_val("t6_off_clkena", int'(lcd_clkena), 0);
    check_val("t6_off_ready", int'(pix_ready), 0);
    check_val("t6_off_underrun", int'(underrun), 1);
    clear_tallies();
    run_ce(40, 0, 0);
    check_val("t6_off_strobes", strobe_cnt, 0);
    check_val("t6_off_hold_ly", int'(ly), 0);
    check_val("t6_off_hold_mode", int'(mode), 0);
    lcd_on = 1'b1;
    ce = 1'b0;
    tick();
    check_val("t6_on_mode", int'(mode), 2);
    check_val("t6_on_ly", int'(ly), 0);
    clear_tallies();
    run_ce(80, 0, 0);
    check_val("t6_no_strobe_80ce", strobe_cnt, 0);
    run_ce(1, 0, 0);
    check_val("t6_strobe_81st_ce", strobe_cnt, 1);
    $display("test6 off/on: strobes after 81 ce=%0d", strobe_cnt);

    // ---- 5: rest of this frame; dot enable every 4th clock around vblank
    done = 0;
    for (int k = 0; k < 80000 && done == 0; k++) begin
      slow = (b_ly == 143 && b_dot >= 200) || (b_ly == 144 && b_dot < 16);
      ce = slow ? 1'(k % 4 == 3) : 1'b1;
      pix_valid = 1'b1;
      pix_data = 15'(b_dot);
      tick();
      if (b_ly == 0 && b_dot == 0) done = 1;
    end
    check_val("t5_frame_done", done, 1);
    check_val("t5_frame_strobes", strobe_cnt, 144 * 160);
    check_val("t5_vs_cycles", vs_cyc, 1);
    check_val("t5_vs_ly", vs_ly, 144);
    check_val("t5_vs_dot", vs_dot, 0);
    check_val("t5_mode_errs", mode_err, 0);
    check_val("t5_ready_without_ce", pr_err, 0);
    check_val("t5_wrap_ly", int'(ly), 0);
    check_val("t5_wrap_mode", int'(mode), 2);
    $display("test5 frame: strobes=%0d vs_cycles=%0d", strobe_cnt, vs_cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
